machine_ctrl: RTL
=================

# machine_ctrl

Instruction-sequencing controller for the 8-bit RISC CPU. It steps a fixed eight-phase fetch/execute cycle and decodes the 3-bit opcode from the instruction register together with the ALU `zero` flag. From these it drives every datapath strobe: PC increment and load, instruction-register load, memory read and write, bus driver enable, accumulator load, and the ALU enable `con_alu`. It is the producer of the control signals that the ALU, PC, IR, accumulator and bus driver consume.

## Interface
Parameters: none. Opcode encoding is fixed: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.

- clk  in  1  single system clock; all state changes on its rising edge
- rst  in  1  reset, synchronous, active-high
- ena  in  1  run enable; low parks the sequencer at phase 0
- opcode  in  3  IR opcode field; stable from phase 2 through phase 7
- zero  in  1  ALU zero flag (1 = accumulator is 0)
- inc_pc  out  1  PC increment strobe
- load_pc  out  1  PC load from IR address field
- load_ir  out  1  IR byte load strobe
- rd  out  1  memory read
- wr  out  1  memory write
- datactl_ena  out  1  accumulator/ALU output drives the data bus
- con_alu  out  1  ALU register enable
- load_acc  out  1  accumulator load from ALU
- halt  out  1  CPU halted (sticky)
- phase  out  3  current phase number, 0..7

## Operation
- State: 3-bit phase register P0..P7, plus a 1-bit halted flag.
- Run: while `ena`=1 and not halted, the phase advances P0→P1→…→P7→P0, one phase per clock.
- Strobes are combinational from (phase, opcode, zero). All strobes are forced to 0 when `rst`=1, `ena`=0 or halted. Strobes not listed below are 0.
- P0: rd=1, load_ir=1 (fetch opcode byte).
- P1: rd=1, load_ir=1, inc_pc=1 (fetch address byte).
- P2: decode; no strobes.
- P3:
  - HLT: halt=1. The halted flag sets on this edge.
  - ADD/AND/XOR/LDA: rd=1 (operand fetch).
  - STO: datactl_ena=1.
  - SKZ/JMP: none.
- P4:
  - ADD/AND/XOR/LDA: rd=1, con_alu=1.
  - STO: datactl_ena=1, wr=1.
  - JMP: load_pc=1.
  - SKZ: inc_pc=`zero`.
- P5:
  - ADD/AND/XOR/LDA: load_acc=1.
  - STO: datactl_ena=1 (hold data one cycle past wr).
  - SKZ: inc_pc=`zero`.
  - The two SKZ increments skip one 2-byte instruction.
- P6: no strobes.
- P7: inc_pc=1 unless opcode is JMP (advances past the address byte of the executed instruction).
- Halt:
  - `halt` output = halted flag OR (P3 and opcode=HLT).
  - Once set, halted persists through any `ena` value and is cleared only by `rst`. Phase freezes at P3 while halted.
- `ena`=0, not halted: the next edge loads phase P0. Any partially executed instruction is abandoned, and no strobe fires in that cycle.

## Timing
- Reset: the edge with `rst`=1 loads phase=0 and halted=0. While `rst`=1, all outputs are 0 and phase reads 0.
- `rst` has priority over `ena` and the halted flag. Reset mid-instruction returns to P0 on the next edge with no further strobes.
- Latency: with `ena` held high, an instruction takes exactly 8 clocks. The first strobe (P0 rd/load_ir) appears in the first cycle after reset releases.
- `zero` is sampled combinationally in P4 and P5. It must remain stable across both phases, because the accumulator changes only at P5 of ALU ops.
- `opcode` is sampled only in P3..P7. Values present in P0..P2 are ignored.
- `wr` is asserted only in P4 and always with datactl_ena=1. datactl_ena is high P3..P5, so data is set up one cycle before wr and held one cycle after.
- rd and wr are never high in the same cycle. load_pc and inc_pc are never high in the same cycle.

## Test plan
- Reset then `ena`=1, opcode=ADD:
  - phase sequence 0,1,…,7,0.
  - rd high in P0,P1,P3,P4; load_ir in P0,P1; con_alu only P4; load_acc only P5; inc_pc in P1,P7.
- opcode=STO:
  - datactl_ena high P3–P5; wr high only P4.
  - rd is 0 in P3..P7, and wr never overlaps rd.
- opcode=SKZ:
  - with zero=1: inc_pc high P1,P4,P5,P7 (4 pulses).
  - with zero=0: inc_pc only P1,P7.
- opcode=JMP: load_pc high only in P4; inc_pc is 0 in P7.
- opcode=HLT:
  - halt rises in P3 and phase stays 3.
  - All other strobes stay 0 for 20 cycles, including toggling `ena`.
  - `rst` pulse clears halt; phase=0.
- `ena` dropped in P4 of ADD: next phase is 0, and no load_acc occurs.
- `rst` asserted in P5 of ADD: same-cycle load_acc is 0 and phase=0 next cycle.

Source files
------------

// File: rtl/machine_ctrl_if.sv
// Control bus between the instruction sequencer and the CPU datapath:
// run enable, opcode and zero flag in; every datapath strobe plus halt/phase out.
interface machine_ctrl_if;
  logic       ena;
  logic [2:0] opcode;
  logic       zero;
  logic       inc_pc;
  logic       load_pc;
  logic       load_ir;
  logic       rd;
  logic       wr;
  logic       datactl_ena;
  logic       con_alu;
  logic       load_acc;
  logic       halt;
  logic [2:0] phase;

  modport master (
    input  ena, opcode, zero,
    output inc_pc, load_pc, load_ir, rd, wr, datactl_ena, con_alu, load_acc, halt, phase
  );

  modport slave (
    output ena, opcode, zero,
    input  inc_pc, load_pc, load_ir, rd, wr, datactl_ena, con_alu, load_acc, halt, phase
  );
endinterface

// File: rtl/machine_ctrl.sv
// Eight-phase fetch/execute sequencer for the 8-bit RISC CPU; strobes are
// combinational from (phase, opcode, zero), state changes on the rising clk edge.
module machine_ctrl (
  input  logic           clk,
  input  logic           rst,
  machine_ctrl_if.master bus
);
  localparam logic [2:0] P0 = 3'd0;
  localparam logic [2:0] P1 = 3'd1;
  localparam logic [2:0] P2 = 3'd2;
  localparam logic [2:0] P3 = 3'd3;
  localparam logic [2:0] P4 = 3'd4;
  localparam logic [2:0] P5 = 3'd5;
  localparam logic [2:0] P6 = 3'd6;
  localparam logic [2:0] P7 = 3'd7;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  logic [2:0] phase_q, phase_d;
  logic       halted_q, halted_d;

  logic active;
  logic is_alu;
  logic hlt_now;
  logic inc_pc, load_pc, load_ir, rd, wr, datactl_ena, con_alu, load_acc;

  assign active  = !rst && bus.ena && !halted_q;
  assign is_alu  = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
                   (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);
  assign hlt_now = active && (phase_q == P3) && (bus.opcode == OP_HLT);

  // Halted parks at P3 regardless of ena; only rst (in always_ff) leaves it.
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (halted_q) begin
      phase_d = P3;
    end else if (!bus.ena) begin
      phase_d = P0;
    end else if (hlt_now) begin
      halted_d = 1'b1;
      phase_d  = P3;
    end else begin
      phase_d = phase_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= P0;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    inc_pc      = 1'b0;
    load_pc     = 1'b0;
    load_ir     = 1'b0;
    rd          = 1'b0;
    wr          = 1'b0;
    datactl_ena = 1'b0;
    con_alu     = 1'b0;
    load_acc    = 1'b0;
    if (active) begin
      case (phase_q)
        P0: begin
          rd      = 1'b1;
          load_ir = 1'b1;
        end
        P1: begin
          rd      = 1'b1;
          load_ir = 1'b1;
          inc_pc  = 1'b1;
        end
        P3: begin
          if (is_alu)                    rd          = 1'b1;
          else if (bus.opcode == OP_STO) datactl_ena = 1'b1;
        end
        P4: begin
          if (is_alu) begin
            rd      = 1'b1;
            con_alu = 1'b1;
          end else if (bus.opcode == OP_STO) begin
            datactl_ena = 1'b1;
            wr          = 1'b1;
          end else if (bus.opcode == OP_JMP) begin
            load_pc = 1'b1;
          end else if (bus.opcode == OP_SKZ) begin
            inc_pc = bus.zero;
          end
        end
        P5: begin
          // Two SKZ increments here and at P4 step over one 2-byte instruction.
          if (is_alu)                    load_acc    = 1'b1;
          else if (bus.opcode == OP_STO) datactl_ena = 1'b1;
          else if (bus.opcode == OP_SKZ) inc_pc      = bus.zero;
        end
        P7: begin
          inc_pc = (bus.opcode != OP_JMP);
        end
        default: ;
      endcase
    end
  end

  assign bus.inc_pc      = inc_pc;
  assign bus.load_pc     = load_pc;
  assign bus.load_ir     = load_ir;
  assign bus.rd          = rd;
  assign bus.wr          = wr;
  assign bus.datactl_ena = datactl_ena;
  assign bus.con_alu     = con_alu;
  assign bus.load_acc    = load_acc;
  assign bus.halt        = !rst && (halted_q || hlt_now);
  assign bus.phase       = rst ? P0 : phase_q;
endmodule
